// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller: FSM states,
// opcodes, ALU operation codes and result-mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    RESET,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    EXEC_LUI,
    EXEC_AUIPC,
    ALU_WB,
    MEM_ADR,
    MEM_RD,
    MEM_WR,
    LOAD_WB,
    BR_CMP,
    BR_TGT,
    JAL,
    TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;

  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_READDATA = 2'b01;
  localparam logic [1:0] RES_PC4      = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode for R-type and I-type arithmetic.
// o_alu_legal is low for funct3 values this datapath cannot execute (shifts, xor, sltu).
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control,
  output logic       o_alu_legal
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_alu_legal   = 1'b1;
    case (i_funct3)
      3'b000:  o_alu_control = (i_op == OP_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  o_alu_control = ALU_AND;
      3'b110:  o_alu_control = ALU_OR;
      3'b010:  o_alu_control = ALU_SLT;
      default: o_alu_legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle sequencer: walks fetch/decode/execute/writeback, time-sharing one ALU
// and waiting on mem_ready for every memory access.
module mc_control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic [2:0] ALUControl,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       InstrReq,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       instr_done,
  output logic       illegal
);

  // state      | meaning
  // RESET      | outputs quiet, go fetch       EXEC_*  | one ALU cycle for R/I/LUI/AUIPC
  // FETCH      | InstrReq until mem_ready      ALU_WB  | write ALU result, PC+4, retire
  // DECODE     | dispatch on opcode            MEM_*   | address, then read/write handshake
  // BR_CMP/TGT | compare into taken, then target;  JAL | link + jump in one cycle
  // TRAP       | illegal instruction, sticky until reset

  state_t     r_state;
  state_t     w_next_state;
  logic       r_taken;
  logic       w_next_taken;
  logic [2:0] w_alu_ctrl;
  logic       w_alu_legal;

  alu_decoder u_alu_decoder (
    .i_op          (op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .o_alu_control (w_alu_ctrl),
    .o_alu_legal   (w_alu_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_taken <= w_next_taken;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_taken = r_taken;
    ALUControl   = ALU_ADD;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 1'b0;
    InstrReq     = 1'b0;
    IRWrite      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RES_ALUOUT;
    PCWrite      = 1'b0;
    PCSrc        = 1'b0;
    instr_done   = 1'b0;
    illegal      = 1'b0;

    case (r_state)
      RESET: w_next_state = FETCH;
      FETCH: begin
        InstrReq = 1'b1;
        if (mem_ready) begin
          IRWrite      = 1'b1;
          w_next_state = DECODE;
        end
      end
      DECODE: begin
        // Unsupported R/I funct3 traps here so EXEC never drives a bogus ALU op.
        case (op)
          OP_R:               w_next_state = w_alu_legal ? EXEC_R : TRAP;
          OP_I:               w_next_state = w_alu_legal ? EXEC_I : TRAP;
          OP_LOAD, OP_STORE:  w_next_state = MEM_ADR;
          OP_BRANCH:          w_next_state = BR_CMP;
          OP_JAL:             w_next_state = JAL;
          OP_LUI:             w_next_state = EXEC_LUI;
          OP_AUIPC:           w_next_state = EXEC_AUIPC;
          default:            w_next_state = TRAP;
        endcase
      end
      EXEC_R: begin
        ALUControl   = w_alu_ctrl;
        w_next_state = ALU_WB;
      end
      EXEC_I: begin
        ALUControl   = w_alu_ctrl;
        ALUSrcB      = 1'b1;
        w_next_state = ALU_WB;
      end
      EXEC_LUI: begin
        ALUControl   = ALU_PASSB;
        ALUSrcB      = 1'b1;
        w_next_state = ALU_WB;
      end
      EXEC_AUIPC: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 1'b1;
        w_next_state = ALU_WB;
      end
      ALU_WB: begin
        RegWrite     = 1'b1;
        ResultSrc    = RES_ALUOUT;
        PCWrite      = 1'b1;
        instr_done   = 1'b1;
        w_next_state = FETCH;
      end
      MEM_ADR: begin
        ALUSrcB      = 1'b1;
        w_next_state = (op == OP_STORE) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        if (mem_ready) w_next_state = LOAD_WB;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        if (mem_ready) begin
          PCWrite      = 1'b1;
          instr_done   = 1'b1;
          w_next_state = FETCH;
        end
      end
      LOAD_WB: begin
        RegWrite     = 1'b1;
        ResultSrc    = RES_READDATA;
        PCWrite      = 1'b1;
        instr_done   = 1'b1;
        w_next_state = FETCH;
      end
      BR_CMP: begin
        ALUControl = ALU_SUB;
        case (funct3)
          F3_BEQ: begin
            w_next_taken = Zero;
            w_next_state = BR_TGT;
          end
          F3_BNE: begin
            w_next_taken = ~Zero;
            w_next_state = BR_TGT;
          end
          default: w_next_state = TRAP;
        endcase
      end
      BR_TGT: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 1'b1;
        PCWrite      = 1'b1;
        PCSrc        = r_taken;
        instr_done   = 1'b1;
        w_next_state = FETCH;
      end
      JAL: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 1'b1;
        RegWrite     = 1'b1;
        ResultSrc    = RES_PC4;
        PCWrite      = 1'b1;
        PCSrc        = 1'b1;
        instr_done   = 1'b1;
        w_next_state = FETCH;
      end
      TRAP:    illegal = 1'b1;
      default: w_next_state = RESET;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each stimulus cycle queues the hand-derived
// output vector for that cycle; a negedge monitor pops and compares it.
module tb_mc_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic [2:0] ALUControl;
  logic       ALUSrcA, ALUSrcB, InstrReq, IRWrite, MemRead, MemWrite, RegWrite;
  logic [1:0] ResultSrc;
  logic       PCWrite, PCSrc, instr_done, illegal;

  mc_control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .InstrReq   (InstrReq),
    .IRWrite    (IRWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: {ALUControl, SrcA, SrcB, InstrReq, IRWrite, MemRead, MemWrite,
  //                 RegWrite, ResultSrc, PCWrite, PCSrc, instr_done, illegal}
  localparam logic [15:0] M_ILL   = 16'h0001;
  localparam logic [15:0] M_DONE  = 16'h0002;
  localparam logic [15:0] M_PCS   = 16'h0004;
  localparam logic [15:0] M_PCW   = 16'h0008;
  localparam logic [15:0] RS_RD   = 16'h0010;
  localparam logic [15:0] RS_PC4  = 16'h0020;
  localparam logic [15:0] M_RW    = 16'h0040;
  localparam logic [15:0] M_MW    = 16'h0080;
  localparam logic [15:0] M_MR    = 16'h0100;
  localparam logic [15:0] M_IRW   = 16'h0200;
  localparam logic [15:0] M_IR    = 16'h0400;
  localparam logic [15:0] M_SB    = 16'h0800;
  localparam logic [15:0] M_SA    = 16'h1000;
  localparam logic [15:0] A_SUB   = 16'h2000;
  localparam logic [15:0] A_AND   = 16'h4000;
  localparam logic [15:0] A_OR    = 16'h6000;
  localparam logic [15:0] A_SLT   = 16'hA000;
  localparam logic [15:0] A_PASSB = 16'hC000;

  localparam logic [15:0] E0       = 16'h0000;
  localparam logic [15:0] FETCH_OK = M_IR | M_IRW;
  localparam logic [15:0] FETCH_W  = M_IR;
  localparam logic [15:0] ALUWB    = M_RW | M_PCW | M_DONE;
  localparam logic [15:0] LDWB     = M_RW | RS_RD | M_PCW | M_DONE;
  localparam logic [15:0] JALV     = M_SA | M_SB | M_RW | RS_PC4 | M_PCW | M_PCS | M_DONE;
  localparam logic [15:0] BRT_T    = M_SA | M_SB | M_PCW | M_PCS | M_DONE;
  localparam logic [15:0] BRT_N    = M_SA | M_SB | M_PCW | M_DONE;
  localparam logic [15:0] MWR_OK   = M_MW | M_PCW | M_DONE;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    logic [15:0] exp;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  wire logic [15:0] w_act = {ALUControl, ALUSrcA, ALUSrcB, InstrReq, IRWrite, MemRead,
                             MemWrite, RegWrite, ResultSrc, PCWrite, PCSrc, instr_done, illegal};

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec++;
      if (w_act !== e.exp) begin
        n_err++;
        $display("FAIL %s (vec %0d): got %h, expected %h", e.nm, n_vec, w_act, e.exp);
      end
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy,
                     input logic [15:0] e, input string nm);
    exp_t item;
    rst_n     = rst;
    op        = o;
    funct3    = f3;
    funct7b5  = f7;
    Zero      = z;
    mem_ready = rdy;
    item.exp  = e;
    item.nm   = nm;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input string nm);
    cyc(1'b1, o, f3, f7, 1'b0, 1'b1, FETCH_OK, {nm, " fetch"});
    cyc(1'b1, o, f3, f7, 1'b0, 1'b1, E0, {nm, " decode"});
  endtask

  task automatic do_reset(input string nm);
    cyc(1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, E0, {nm, " rst low"});
    cyc(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, E0, {nm, " rst release"});
  endtask

  initial begin
    rst_n = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset: three cycles low with mem_ready high, then RESET for one more cycle.
    for (int i = 0; i < 3; i++) cyc(1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b1, E0, "reset held");
    cyc(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, E0, "reset state");

    // R-type sub, retire at cycle 4
    fetch_decode(OP_R, 3'b000, 1'b1, "sub");
    cyc(1'b1, OP_R, 3'b000, 1'b1, 1'b0, 1'b0, A_SUB, "sub exec");
    cyc(1'b1, OP_R, 3'b000, 1'b1, 1'b0, 1'b0, ALUWB, "sub wb");

    // R-type and; fetch waits one cycle first
    cyc(1'b1, OP_R, 3'b111, 1'b0, 1'b0, 1'b0, FETCH_W, "and fetch wait");
    fetch_decode(OP_R, 3'b111, 1'b0, "and");
    cyc(1'b1, OP_R, 3'b111, 1'b0, 1'b0, 1'b0, A_AND, "and exec");
    cyc(1'b1, OP_R, 3'b111, 1'b0, 1'b0, 1'b0, ALUWB, "and wb");

    // addi with funct7b5 set stays add; ori; slti
    fetch_decode(OP_I, 3'b000, 1'b1, "addi");
    cyc(1'b1, OP_I, 3'b000, 1'b1, 1'b0, 1'b0, M_SB, "addi exec");
    cyc(1'b1, OP_I, 3'b000, 1'b1, 1'b0, 1'b0, ALUWB, "addi wb");
    fetch_decode(OP_I, 3'b110, 1'b0, "ori");
    cyc(1'b1, OP_I, 3'b110, 1'b0, 1'b0, 1'b0, A_OR | M_SB, "ori exec");
    cyc(1'b1, OP_I, 3'b110, 1'b0, 1'b0, 1'b0, ALUWB, "ori wb");
    fetch_decode(OP_I, 3'b010, 1'b0, "slti");
    cyc(1'b1, OP_I, 3'b010, 1'b0, 1'b0, 1'b0, A_SLT | M_SB, "slti exec");
    cyc(1'b1, OP_I, 3'b010, 1'b0, 1'b0, 1'b0, ALUWB, "slti wb");

    // LUI, AUIPC, JAL
    fetch_decode(OP_LUI, 3'b000, 1'b0, "lui");
    cyc(1'b1, OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, A_PASSB | M_SB, "lui exec");
    cyc(1'b1, OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, ALUWB, "lui wb");
    fetch_decode(OP_AUI, 3'b000, 1'b0, "auipc");
    cyc(1'b1, OP_AUI, 3'b000, 1'b0, 1'b0, 1'b0, M_SA | M_SB, "auipc exec");
    cyc(1'b1, OP_AUI, 3'b000, 1'b0, 1'b0, 1'b0, ALUWB, "auipc wb");
    fetch_decode(OP_JAL, 3'b000, 1'b0, "jal");
    cyc(1'b1, OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, JALV, "jal");

    // Branches: taken flag from Zero during BR_CMP
    fetch_decode(OP_BR, 3'b000, 1'b0, "beq z1");
    cyc(1'b1, OP_BR, 3'b000, 1'b0, 1'b1, 1'b0, A_SUB, "beq z1 cmp");
    cyc(1'b1, OP_BR, 3'b000, 1'b0, 1'b0, 1'b0, BRT_T, "beq z1 tgt");
    fetch_decode(OP_BR, 3'b001, 1'b0, "bne z1");
    cyc(1'b1, OP_BR, 3'b001, 1'b0, 1'b1, 1'b0, A_SUB, "bne z1 cmp");
    cyc(1'b1, OP_BR, 3'b001, 1'b0, 1'b0, 1'b0, BRT_N, "bne z1 tgt");
    fetch_decode(OP_BR, 3'b001, 1'b0, "bne z0");
    cyc(1'b1, OP_BR, 3'b001, 1'b0, 1'b0, 1'b0, A_SUB, "bne z0 cmp");
    cyc(1'b1, OP_BR, 3'b001, 1'b0, 1'b1, 1'b0, BRT_T, "bne z0 tgt");
    fetch_decode(OP_BR, 3'b000, 1'b0, "beq z0");
    cyc(1'b1, OP_BR, 3'b000, 1'b0, 1'b0, 1'b0, A_SUB, "beq z0 cmp");
    cyc(1'b1, OP_BR, 3'b000, 1'b0, 1'b1, 1'b0, BRT_N, "beq z0 tgt");

    // Store with one wait state
    fetch_decode(OP_ST, 3'b010, 1'b0, "sw");
    cyc(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, M_SB, "sw adr");
    cyc(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, M_MW, "sw wait");
    cyc(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b1, MWR_OK, "sw done");

    // Load with three wait states: 8 cycles total
    fetch_decode(OP_LD, 3'b010, 1'b0, "lw");
    cyc(1'b1, OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, M_SB, "lw adr");
    for (int i = 0; i < 3; i++) cyc(1'b1, OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, M_MR, "lw wait");
    cyc(1'b1, OP_LD, 3'b010, 1'b0, 1'b0, 1'b1, M_MR, "lw rdy");
    cyc(1'b1, OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, LDWB, "lw wb");

    // Reset during MEM_WR aborts with no retire
    fetch_decode(OP_ST, 3'b010, 1'b0, "sw abort");
    cyc(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, M_SB, "sw abort adr");
    cyc(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, M_MW, "sw abort wait");
    cyc(1'b0, OP_ST, 3'b010, 1'b0, 1'b0, 1'b1, E0, "sw abort rst");
    cyc(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b1, E0, "sw abort release");
    cyc(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b1, FETCH_OK, "restart fetch");
    cyc(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, E0, "restart decode");
    cyc(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, M_SB, "restart adr");
    cyc(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b1, MWR_OK, "restart sw done");

    // Illegal opcode: sticky TRAP even with mem_ready high
    fetch_decode(OP_BAD, 3'b000, 1'b0, "bad op");
    for (int i = 0; i < 3; i++) cyc(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b1, M_ILL, "bad op trap");
    do_reset("bad op");
    // Unsupported I-type funct3 (shift)
    fetch_decode(OP_I, 3'b001, 1'b0, "slli");
    for (int i = 0; i < 2; i++) cyc(1'b1, OP_I, 3'b001, 1'b0, 1'b0, 1'b1, M_ILL, "slli trap");
    do_reset("slli");
    // Unsupported branch funct3 traps after the compare cycle
    fetch_decode(OP_BR, 3'b100, 1'b0, "blt");
    cyc(1'b1, OP_BR, 3'b100, 1'b0, 1'b0, 1'b0, A_SUB, "blt cmp");
    cyc(1'b1, OP_BR, 3'b100, 1'b0, 1'b0, 1'b1, M_ILL, "blt trap");
    do_reset("blt");
    cyc(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, FETCH_W, "final fetch");

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
